// File: rtl/bin2bcd_pkg.sv
// +--------------------------------------------------------------------------+
// | bin2bcd_pkg - shared types and constants for the bin2bcd_seq converter    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_BLANK      = 4'hF;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Smallest digit count whose decimal range covers every WIDTH-bit value.
  function automatic int digits_for_width(input int w);
    logic [127:0] max_val;
    logic [127:0] pow;
    int           d;
    max_val = (128'd1 << w) - 128'd1;
    pow     = 128'd1;
    d       = 0;
    for (int i = 0; i < 40; i++) begin
      if (pow <= max_val) begin
        pow = pow * 128'd10;
        d   = d + 1;
      end
    end
    return (d < 1) ? 1 : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// +--------------------------------------------------------------------------+
// | bcd_digit_adj - combinational add-3-if-at-least-5 digit correction        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD) : digit_in;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// +--------------------------------------------------------------------------+
// | bin2bcd_seq - sequential double-dabble binary to packed BCD converter     |
// | Optional BIN2BCD_BLANK_EN: leading-zero digits presented as 4'hF          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH);

  if (DIGITS < digits_for_width(WIDTH)) begin : g_param_check
    $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
  end

  state_t              r_state;
  state_t              w_next_state;
  logic                w_load;
  logic                w_shift;
  logic                w_finish;
  logic [WIDTH-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_acc;
  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_final;
  logic [4*DIGITS-1:0] r_bcd;
  logic [CNT_W-1:0]    r_count;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit_adj
    bcd_digit_adj u_adj (
      .digit_in  (r_acc[4*k +: 4]),
      .digit_out (w_adj[4*k +: 4])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // SHIFT spends one extra cycle after the last iteration to register the result.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    in_ready     = (r_state == IDLE);
    out_valid    = (r_state == DONE);
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (r_count == C_LAST) begin
          w_finish     = 1'b1;
          w_next_state = DONE;
        end else begin
          w_shift = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

`ifdef BIN2BCD_BLANK_EN
  always_comb begin : blank_comb
    logic lead;
    w_final = r_acc;
    lead    = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (r_acc[4*k +: 4] == 4'd0)) w_final[4*k +: 4] = BCD_BLANK;
      else                                    lead = 1'b0;
    end
  end
`else
  assign w_final = r_acc;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bin   <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_bcd   <= '0;
    end else begin
      if (w_load) begin
        r_bin   <= bin_in;
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_shift) begin
        r_acc   <= (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_bin[WIDTH-1]};
        r_bin   <= r_bin << 1;
        r_count <= r_count + CNT_W'(1);
      end
      if (w_finish) r_bcd <= w_final;
    end
  end

  assign bcd_out = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// +--------------------------------------------------------------------------+
// | tb_bin2bcd_seq - directed self-checking bench for bin2bcd_seq             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bin2bcd_seq;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bin_in;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] bcd_out;

  int n_checks;
  int n_fail;
  int cyc;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected value for the active build: raw digits or leading-zero blanked digits.
  function automatic logic [19:0] sel(input logic [19:0] raw, input logic [19:0] blk);
`ifdef BIN2BCD_BLANK_EN
    return blk;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic accept(input logic [15:0] v);
    @(negedge clk);
    bin_in   = v;
    in_valid = 1'b1;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_fall", {31'd0, out_valid}, 32'd0);
    check("in_ready_rise", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic convert(input string tag, input logic [15:0] v, input logic [19:0] exp);
    int lat;
    accept(v);
    wait_done(lat);
    check({tag, "_latency"}, lat, 32'd17);
    check(tag, {12'd0, bcd_out}, {12'd0, exp});
    release_out();
  endtask

  initial begin : main
    int lat;
    int t0;
    int t1;
    int guard;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bcd_out", {12'd0, bcd_out}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    convert("zero", 16'd0, sel(20'h00000, 20'hFFFF0));
    convert("max", 16'd65535, sel(20'h65535, 20'h65535));
    convert("ten_k", 16'd10000, sel(20'h10000, 20'h10000));
    convert("n9999", 16'd9999, sel(20'h09999, 20'hF9999));

    // Held output with out_ready low.
    accept(16'd1234);
    wait_done(lat);
    check("hold_latency", lat, 32'd17);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_bcd", {12'd0, bcd_out}, {12'd0, sel(20'h01234, 20'hF1234)});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    release_out();

    // Back-to-back with in_valid held high.
    @(negedge clk);
    bin_in    = 16'd9;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    t0     = cyc;
    bin_in = 16'd10;
    wait_done(lat);
    check("b2b_first", {12'd0, bcd_out}, {12'd0, sel(20'h00009, 20'hFFFF9)});
    guard = 0;
    while (!in_ready && guard < 40) begin
      step();
      guard++;
    end
    step();
    t1       = cyc;
    in_valid = 1'b0;
    check("b2b_spacing", t1 - t0, 32'd19);
    wait_done(lat);
    check("b2b_second", {12'd0, bcd_out}, {12'd0, sel(20'h00010, 20'hFFF10)});
    step();
    out_ready = 1'b0;
    check("b2b_idle", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of SHIFT.
    accept(16'd4321);
    repeat (8) step();
    check("mid_in_ready", {31'd0, in_ready}, 32'd0);
    resetn = 1'b0;
    #2;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_bcd", {12'd0, bcd_out}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    convert("after_rst", 16'd42, sel(20'h00042, 20'hFFF42));

    // Input changes after acceptance are ignored.
    accept(16'd1111);
    bin_in   = 16'd2222;
    in_valid = 1'b1;
    wait_done(lat);
    in_valid = 1'b0;
    check("ignore_latency", lat, 32'd17);
    check("ignore_change", {12'd0, bcd_out}, {12'd0, sel(20'h01111, 20'hF1111)});
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
